// File: rtl/arc4_pkg.sv
// Shared types and constants for the ARC4 key-cracking datapath.
package arc4_pkg;

  typedef logic [7:0] byte_t;

  localparam byte_t PRINT_LO        = 8'h20;
  localparam byte_t PRINT_HI        = 8'h7E;
  localparam int    MSG_MAX_DEFAULT = 255;

  typedef enum logic [3:0] {
    IDLE,
    RD_LEN,
    WR_LEN,
    ADV_I,
    RD_SI,
    RD_SJ,
    WR_SI,
    WR_SJ,
    RD_PAD,
    WR_PT,
    DONE
  } prga_state_t;

endpackage

// File: rtl/printable_chk.sv
// Combinational check that a byte lies in the printable ASCII range.
module printable_chk
  import arc4_pkg::*;
(
  input  logic [7:0] byte_i,
  output logic       ok_o
);

  assign ok_o = (byte_i >= PRINT_LO) && (byte_i <= PRINT_HI);

endmodule

// File: rtl/prga_check.sv
// ARC4 keystream/decrypt stage: decrypts length-prefixed CT into PT using S,
// aborting on the first non-printable plaintext byte.
module prga_check
  import arc4_pkg::*;
#(
  parameter int MSG_MAX = MSG_MAX_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  output logic       rdy,
  output logic       pt_ok,
  output logic [7:0] s_addr,
  input  logic [7:0] s_rddata,
  output logic [7:0] s_wrdata,
  output logic       s_wren,
  output logic [7:0] ct_addr,
  input  logic [7:0] ct_rddata,
  output logic [7:0] pt_addr,
  output logic [7:0] pt_wrdata,
  output logic       pt_wren
);

  // state  | meaning
  // IDLE   | ready, waiting for en
  // RD_LEN | read ct[0]
  // WR_LEN | clamp length, write pt[0], reset i/j/k
  // ADV_I  | advance i for the next keystream byte
  // RD_SI  | read s[i]
  // RD_SJ  | capture si, update j, read s[j]
  // WR_SI  | capture sj, write s[i]=sj
  // WR_SJ  | write s[j]=si
  // RD_PAD | read s[si+sj] and ct[k] together
  // WR_PT  | write pt[k], check printability, loop or finish
  // DONE   | ready, pt_ok valid; en here restarts immediately

  localparam byte_t MSG_MAX_B = byte_t'(MSG_MAX);

  prga_state_t state_q, state_d;
  byte_t       i_q, i_d;
  byte_t       j_q, j_d;
  byte_t       k_q, k_d;
  byte_t       len_q, len_d;
  byte_t       si_q, si_d;
  byte_t       sj_q, sj_d;
  logic        pt_ok_q, pt_ok_d;

  byte_t       pt_byte;
  byte_t       len_clamped;
  byte_t       j_next;
  logic        pt_printable;

  assign pt_byte     = s_rddata ^ ct_rddata;
  assign len_clamped = (ct_rddata > MSG_MAX_B) ? MSG_MAX_B : ct_rddata;
  assign j_next      = j_q + s_rddata;
  assign pt_ok       = pt_ok_q;

  printable_chk u_printable (
    .byte_i (pt_byte),
    .ok_o   (pt_printable)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      i_q     <= '0;
      j_q     <= '0;
      k_q     <= '0;
      len_q   <= '0;
      si_q    <= '0;
      sj_q    <= '0;
      pt_ok_q <= 1'b0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      k_q     <= k_d;
      len_q   <= len_d;
      si_q    <= si_d;
      sj_q    <= sj_d;
      pt_ok_q <= pt_ok_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    i_d       = i_q;
    j_d       = j_q;
    k_d       = k_q;
    len_d     = len_q;
    si_d      = si_q;
    sj_d      = sj_q;
    pt_ok_d   = pt_ok_q;
    rdy       = 1'b0;
    s_addr    = '0;
    s_wrdata  = '0;
    s_wren    = 1'b0;
    ct_addr   = '0;
    pt_addr   = '0;
    pt_wrdata = '0;
    pt_wren   = 1'b0;

    unique case (state_q)
      IDLE: begin
        rdy = 1'b1;
        if (en) begin
          pt_ok_d = 1'b0;
          state_d = RD_LEN;
        end
      end

      RD_LEN: begin
        ct_addr = '0;
        state_d = WR_LEN;
      end

      WR_LEN: begin
        len_d     = len_clamped;
        pt_addr   = '0;
        pt_wrdata = len_clamped;
        pt_wren   = 1'b1;
        i_d       = '0;
        j_d       = '0;
        k_d       = 8'd1;
        if (len_clamped == '0) begin
          pt_ok_d = 1'b1;
          state_d = DONE;
        end else begin
          state_d = ADV_I;
        end
      end

      ADV_I: begin
        i_d     = i_q + 8'd1;
        state_d = RD_SI;
      end

      RD_SI: begin
        s_addr  = i_q;
        state_d = RD_SJ;
      end

      RD_SJ: begin
        si_d    = s_rddata;
        j_d     = j_next;
        s_addr  = j_next;
        state_d = WR_SI;
      end

      WR_SI: begin
        sj_d     = s_rddata;
        s_addr   = i_q;
        s_wrdata = s_rddata;
        s_wren   = 1'b1;
        state_d  = WR_SJ;
      end

      // When i==j this rewrites the same cell with its original value.
      WR_SJ: begin
        s_addr   = j_q;
        s_wrdata = si_q;
        s_wren   = 1'b1;
        state_d  = RD_PAD;
      end

      RD_PAD: begin
        s_addr  = si_q + sj_q;
        ct_addr = k_q;
        state_d = WR_PT;
      end

      // k is compared before incrementing so len=255 never needs a ninth bit.
      WR_PT: begin
        pt_addr   = k_q;
        pt_wrdata = pt_byte;
        pt_wren   = 1'b1;
        if (!pt_printable) begin
          pt_ok_d = 1'b0;
          state_d = DONE;
        end else if (k_q == len_q) begin
          pt_ok_d = 1'b1;
          state_d = DONE;
        end else begin
          k_d     = k_q + 8'd1;
          state_d = ADV_I;
        end
      end

      DONE: begin
        rdy = 1'b1;
        if (en) begin
          pt_ok_d = 1'b0;
          state_d = RD_LEN;
        end else begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

endmodule
